// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared constants and state type for the instruction fetch queue
package riscv_fetch_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] INS_NOP      = 32'h0000_0013;

  // RUN: fresh responses only; DRAIN: stale responses still owed by memory
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_t;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - registered circular buffer of {pc, instruction} entries with flush
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop frees the slot this same edge, so a full buffer still takes a push
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - credit-based instruction fetch queue with redirect flush and stale-response drop
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              MAX_OUTST = DEPTH
) (
  input  logic            CLK,
  input  logic            RESET,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [XLEN-1:0] ins_data,
  output logic [XLEN-1:0] ins_addr,
  output logic            misalign
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = 2 * XLEN;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_aligned;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   outst_next;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   drop_next;
  logic [CW-1:0]   occ;
  fetch_state_t    state;
  fetch_state_t    state_next;
  logic            credit_ok;
  logic            accept;
  logic            discard;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;
  logic [FW-1:0]   head;

  // stale requests still hold credit until their response comes back
  assign credit_ok = ((int'(occ) + int'(outst)) < DEPTH) && (int'(outst) < MAX_OUTST);

  assign imem_req_valid   = !RESET && credit_ok;
  assign imem_req_addr    = fetch_pc;
  assign accept           = imem_req_valid && imem_req_ready;
  assign discard          = (state == ST_DRAIN);
  assign push             = imem_rsp_valid && !discard && !redirect_valid;
  assign pop              = ins_valid && ins_ready;
  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  assign ins_valid = !empty;
  assign ins_addr  = head[FW-1:XLEN];
  assign ins_data  = head[XLEN-1:0];

  always_comb begin
    outst_next = outst;
    if (accept && !imem_rsp_valid)      outst_next = outst + 1'b1;
    else if (!accept && imem_rsp_valid) outst_next = outst - 1'b1;

    drop_next = drop;
    if (redirect_valid)                 drop_next = outst_next;
    else if (imem_rsp_valid && discard) drop_next = drop - 1'b1;

    state_next = (drop_next != '0) ? ST_DRAIN : ST_RUN;
  end

  // responses come back in order, so the tag of the next fresh one is a running PC
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
      state    <= ST_RUN;
      misalign <= 1'b0;
    end else begin
      outst    <= outst_next;
      drop     <= drop_next;
      state    <= state_next;
      misalign <= redirect_valid && is_misaligned(redirect_pc[1:0]);
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(4);
        if (push)   rsp_pc   <= rsp_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (CLK),
    .reset     (RESET),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .count     (occ)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized scoreboard bench for fetch_queue with directed scenarios
module tb_fetch_queue;

  localparam int          XLEN      = 32;
  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = DEPTH;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic [31:0] ins_addr;
  logic        misalign;

  fetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data), .ins_addr(ins_addr),
    .misalign(misalign)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } ins_t;

  mreq_t       mq[$];
  ins_t        eq[$];
  int          total = 0, bad = 0;
  int          cyc = 0, epoch = 0, last_due = 0, n_acc = 0, n_stale = 0;
  logic [31:0] mpc = RESET_PC;
  logic        exp_mis = 1'b0;
  int          rdy_pct = 100, ins_pct = 100, redir_pct = 0, lat_min = 1, lat_max = 1;
  logic        dir_redir = 1'b0;
  logic [31:0] dir_pc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory and consumer drivers, updated 2 time units after each rising edge
  initial begin
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; ins_ready = 1'b0;
    forever begin
      @(posedge CLK); #2;
      cyc++;
      imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
      ins_ready      = (int'($urandom_range(99)) < ins_pct);
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mq[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      if (dir_redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = dir_pc;
      end else if (int'($urandom_range(99)) < redir_pct) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                  : ($urandom & 32'h0000_0FFF);
      end else begin
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
      end
    end
  end

  // reference model: epochs separate fresh responses from those owed to a flushed stream
  initial begin
    mreq_t r;
    int    due;
    forever begin
      @(negedge CLK); #1;
      if (RESET) begin
        mq.delete(); eq.delete();
        mpc = RESET_PC; exp_mis = 1'b0; last_due = 0;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          r.addr = mpc; r.epoch = epoch; r.due = due;
          mq.push_back(r);
          mpc = mpc + 32'd4;
          n_acc++;
        end
        if (imem_rsp_valid && mq.size() > 0) begin
          r = mq.pop_front();
          if (r.epoch == epoch && !redirect_valid) eq.push_back('{r.addr, mem_word(r.addr)});
          else n_stale++;
        end
        exp_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
        if (redirect_valid) begin
          epoch++;
          eq.delete();
          mpc = {redirect_pc[31:2], 2'b00};
        end
      end
    end
  end

  // monitor: compares every cycle at the falling edge, pops on consumer handshake
  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        check("req_valid", 32'(imem_req_valid),
              32'((eq.size() + mq.size() < DEPTH) && (mq.size() < MAX_OUTST)));
        check("req_addr", imem_req_addr, mpc);
        check("misalign", 32'(misalign), 32'(exp_mis));
        check("ins_valid", 32'(ins_valid), 32'(eq.size() != 0));
        if (ins_valid && eq.size() != 0) begin
          check("ins_addr", ins_addr, eq[0].addr);
          check("ins_data", ins_data, eq[0].data);
          if (ins_ready) void'(eq.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    #4;
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_ins_valid", 32'(ins_valid), 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    check("rst_ins_data", ins_data, 32'h0);
    check("rst_ins_addr", ins_addr, 32'h0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    step();
    RESET = 1'b0;
  endtask

  task automatic set_knobs(input int rdy, input int ins, input int redir, input int lmin, input int lmax);
    rdy_pct = rdy; ins_pct = ins; redir_pct = redir; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic wait_first(input string name, input logic [31:0] want, output int waited);
    waited = -1;
    for (int i = 0; i < 30; i++) begin
      #4;
      if (ins_valid) begin
        waited = i;
        check({name, "_addr"}, ins_addr, want);
        check({name, "_data"}, ins_data, mem_word(want));
        break;
      end
      step();
    end
    if (waited < 0) check({name, "_timeout"}, 32'h1, 32'h0);
  endtask

  initial begin
    int a0, s0, waited;
    logic [31:0] held;
    step();

    // back-to-back stream after reset
    set_knobs(100, 100, 0, 1, 1);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      #4;
      if (k < 2) check("start_idle", 32'(ins_valid), 32'h0);
      else begin
        check("start_valid", 32'(ins_valid), 32'h1);
        check("start_addr", ins_addr, RESET_PC + 32'(4 * (k - 2)));
      end
      step();
    end

    // consumer stalled: credit stops at DEPTH, resumes one cycle after the first pop
    set_knobs(100, 0, 0, 1, 1);
    do_reset();
    a0 = n_acc;
    repeat (10) step();
    #4;
    check("fill_reqs", 32'(n_acc - a0), 32'd4);
    check("fill_stop", 32'(imem_req_valid), 32'h0);
    check("fill_full", 32'(ins_valid), 32'h1);
    ins_pct = 100;
    step(); #4;
    check("pop_cycle_req", 32'(imem_req_valid), 32'h0);
    step(); #4;
    check("resume_req", 32'(imem_req_valid), 32'h1);
    step();

    // redirect with three requests in flight at latency 3
    set_knobs(100, 100, 0, 3, 3);
    do_reset();
    s0 = n_stale;
    step(); step();
    dir_pc = 32'h100; dir_redir = 1'b1;
    step();
    dir_redir = 1'b0;
    wait_first("drain_first", 32'h100, waited);
    check("drain_latency", 32'(waited), 32'd4);
    check("drain_stale", 32'(n_stale - s0), 32'd3);
    step();

    // misaligned redirect
    set_knobs(100, 100, 0, 1, 1);
    do_reset();
    repeat (3) step();
    dir_pc = 32'h102; dir_redir = 1'b1;
    step();
    dir_redir = 1'b0;
    #4;
    check("mis_pulse", 32'(misalign), 32'h1);
    check("mis_flushed", 32'(ins_valid), 32'h0);
    step(); #4;
    check("mis_end", 32'(misalign), 32'h0);
    step();
    wait_first("mis_first", 32'h100, waited);
    step();

    // request stall holds address; redirect during stall moves it
    set_knobs(100, 100, 0, 1, 1);
    do_reset();
    repeat (3) step();
    rdy_pct = 0;
    for (int k = 0; k < 5; k++) begin
      #4;
      held = imem_req_addr;
      check("stall_addr", held, 32'hC);
      check("stall_valid", 32'(imem_req_valid), 32'h1);
      step();
    end
    dir_pc = 32'h200; dir_redir = 1'b1;
    step();
    dir_redir = 1'b0;
    #4;
    check("stall_redirect_addr", imem_req_addr, 32'h200);
    rdy_pct = 100;
    step();

    // randomized traffic
    set_knobs(70, 60, 3, 1, 4);
    repeat (3000) step();
    set_knobs(90, 95, 8, 1, 2);
    repeat (1500) step();
    set_knobs(100, 100, 0, 1, 1);
    repeat (500) step();

    // reset in the middle of a burst
    set_knobs(80, 70, 2, 1, 3);
    repeat (50) step();
    RESET = 1'b1;
    step(); #4;
    check("midrst_ins_valid", 32'(ins_valid), 32'h0);
    step();
    RESET = 1'b0;
    #4;
    check("midrst_addr", imem_req_addr, RESET_PC);
    check("midrst_req", 32'(imem_req_valid), 32'h1);
    set_knobs(100, 100, 0, 1, 1);
    step();
    wait_first("midrst_first", RESET_PC, waited);
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning buffer entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address.
REQ-004 SHALL have parameter MAX_OUTST, default DEPTH, meaning maximum in-flight memory requests.
REQ-005 Ports (name direction width meaning):
- CLK  in  1  sole clock; all state changes on rising edge.
- RESET  in  1  reset, synchronous and active-high.
- imem_req_valid  out  1  fetch request issued.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  in-order response, any latency >=1 cycle.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  XLEN  new fetch address.
- ins_valid  out  1  head entry valid.
- ins_ready  in  1  consumer takes head.
- ins_data  out  XLEN  instruction at head.
- ins_addr  out  XLEN  PC of head instruction.
- misalign  out  1  pulse: redirect_pc[1:0] != 0.

Function
REQ-006 Request handshake: transfer when imem_req_valid & imem_req_ready; imem_req_addr SHALL hold stable while valid & !ready, except on redirect.
REQ-007 Request issued only if occupancy + outstanding < DEPTH and outstanding < MAX_OUTST (credit rule; no response may ever be lost).
REQ-008 fetch_pc SHALL increment by 4 per accepted request, wrapping modulo 2^XLEN.
REQ-009 Responses SHALL enter buffer in arrival order tagged with request PC; outstanding decrements per response.
REQ-010 Consumer handshake: pop when ins_valid & ins_ready; ins_data/ins_addr stable while valid & !ready.
REQ-011 Latency: response in cycle N visible on ins_valid in cycle N+1 (registered buffer, no bypass).
REQ-012 Simultaneous push and pop when full SHALL be allowed; occupancy unchanged.
REQ-013 Redirect (cycle N): buffer emptied, ins_valid=0 in N+1; fetch_pc := {redirect_pc[XLEN-1:2],2'b00}; imem_req_valid may assert with new address in N+1.
REQ-014 Redirect: drop counter := outstanding after same-cycle accept/response; subsequent responses discarded while drop>0, each decrementing it.
REQ-015 Request accepted in redirect cycle N SHALL be counted as stale (dropped).
REQ-016 Pop in redirect cycle SHALL be honoured (consumer owns it); no other entry survives.
REQ-017 misalign SHALL pulse 1 cycle (N+1) when redirect_pc[1:0]!=0; address still aligned down.
REQ-018 States: RUN (issuing per credit), DRAIN (drop>0, new requests still allowed), transitions DRAIN->RUN when drop reaches 0; outstanding counts stale+fresh.
REQ-019 Counters sized $clog2(DEPTH+1) bits; SHALL never overflow or underflow.

Reset
REQ-020 While RESET=1 at edge: fetch_pc=RESET_PC, buffer empty, outstanding=0, drop=0, state=RUN.
REQ-021 Outputs during/after reset: imem_req_valid=0 in reset cycle, ins_valid=0, misalign=0, ins_data=0, ins_addr=0, imem_req_addr=RESET_PC.
REQ-022 Reset mid-operation SHALL abandon in-flight requests; memory side is reset by same RESET, so no drop tracking across reset.

Structure
REQ-023 Shared package riscv_fetch_pkg SHALL hold XLEN default, INS_NOP (32'h0000_0013), fetch state enum.
REQ-024 Buffer SHALL be sub-module fetch_fifo (parametrised width 2*XLEN, DEPTH, with flush input); control stays in fetch_queue.

Verification
REQ-025 Reset, imem ready=1, latency 1, ins_ready=1 -> ins_addr 0,4,8,12 on consecutive cycles, one per cycle after 2-cycle start.
REQ-026 ins_ready=0, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0; ins_ready=1 -> request resumes one cycle after first pop.
REQ-027 Latency 3, 3 outstanding, redirect to 0x100 -> 3 stale responses discarded, first ins_addr=0x100 with its data.
REQ-028 Redirect to 0x102 -> misalign pulse 1 cycle, next ins_addr=0x100.
REQ-029 imem_req_ready=0 for 5 cycles -> imem_req_addr held constant; redirect during stall -> addr changes next cycle to new PC.
REQ-030 Full buffer, simultaneous response+pop -> occupancy stays 4, order preserved; RESET mid-burst -> ins_valid=0 next cycle, fetch restarts at RESET_PC.
